// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: widths, ALU function codes,
// FSM state encoding and the response payload.
package alu_seq_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned CNT_W     = 4;

    // ALU function codes
    localparam logic [OP_W-1:0] OP_ADD    = 4'd0;   // a + b
    localparam logic [OP_W-1:0] OP_SUB_AB = 4'd1;   // a - b
    localparam logic [OP_W-1:0] OP_SUB_BA = 4'd2;   // b - a
    localparam logic [OP_W-1:0] OP_ZERO   = 4'd3;   // 0
    localparam logic [OP_W-1:0] OP_ONE    = 4'd4;   // 1
    localparam logic [OP_W-1:0] OP_ONES   = 4'd5;   // 0xFFFF
    localparam logic [OP_W-1:0] OP_NEG_A  = 4'd6;   // -a
    localparam logic [OP_W-1:0] OP_NEG_B  = 4'd7;   // -b
    localparam logic [OP_W-1:0] OP_NOT_A  = 4'd8;   // ~a
    localparam logic [OP_W-1:0] OP_NOT_B  = 4'd9;   // ~b
    localparam logic [OP_W-1:0] OP_INC_A  = 4'd10;  // a + 1
    localparam logic [OP_W-1:0] OP_INC_B  = 4'd11;  // b + 1
    localparam logic [OP_W-1:0] OP_DEC_A  = 4'd12;  // a - 1
    localparam logic [OP_W-1:0] OP_DEC_B  = 4'd13;  // b - 1
    localparam logic [OP_W-1:0] OP_AND    = 4'd14;  // a & b
    localparam logic [OP_W-1:0] OP_OR     = 4'd15;  // a | b

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Response payload presented on the rsp_* port
    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [REG_IDX_W-1:0] dst;
        logic                 zero;
        logic                 neg;
    } rsp_t;

endpackage

// File: rtl/alu.sv
// 16-bit, 16-function combinational ALU driven by alu_sequencer.
// Ports: a, b operands; s function code; out result (modulo 2^16).
module ALU
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   s,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = '0;
        case (s)
            OP_ADD:    out = a + b;
            OP_SUB_AB: out = a - b;
            OP_SUB_BA: out = b - a;
            OP_ZERO:   out = '0;
            OP_ONE:    out = DATA_W'(1);
            OP_ONES:   out = '1;
            OP_NEG_A:  out = DATA_W'(0) - a;
            OP_NEG_B:  out = DATA_W'(0) - b;
            OP_NOT_A:  out = ~a;
            OP_NOT_B:  out = ~b;
            OP_INC_A:  out = a + DATA_W'(1);
            OP_INC_B:  out = b + DATA_W'(1);
            OP_DEC_A:  out = a - DATA_W'(1);
            OP_DEC_B:  out = b - DATA_W'(1);
            OP_AND:    out = a & b;
            OP_OR:     out = a | b;
            default:   out = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_regfile.sv
// 4x16 register file: two combinational read ports, one synchronous write port,
// asynchronous clear.
// Ports: clk, rst_n; ra_idx/ra_data_c, rb_idx/rb_data_c read ports; we/wa/wd write port.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra_idx,
    input  logic [REG_IDX_W-1:0] rb_idx,
    output logic [DATA_W-1:0]    ra_data_c,
    output logic [DATA_W-1:0]    rb_data_c,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[wa] <= wd;
        end
    end

    assign ra_data_c = regs_q[ra_idx];
    assign rb_data_c = regs_q[rb_idx];

endmodule

// File: rtl/alu_sequencer.sv
// Command front end for the combinational ALU: accepts load/ALU commands,
// holds operands for SETTLE cycles, writes the result back and returns it.
// Ports: clk, rst_n; cmd_* command port (valid/ready); alu_a/alu_b/alu_s to the
// ALU, alu_out from it; rsp_* response port (valid/ready) with zero/neg flags.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_load,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_dst,
    input  logic [REG_IDX_W-1:0] cmd_srca,
    input  logic [REG_IDX_W-1:0] cmd_srcb,
    input  logic [DATA_W-1:0]    cmd_imm,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP_W-1:0]      alu_s,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [REG_IDX_W-1:0] rsp_dst,
    output logic                 rsp_zero,
    output logic                 rsp_neg
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_IDX_W-1:0] dst_q;
    rsp_t                 rsp_q;

    logic [DATA_W-1:0]    ra_data_c, rb_data_c;
    logic                 start_exec_c;
    logic                 wb_en_c;
    logic [REG_IDX_W-1:0] wb_idx_c;
    logic [DATA_W-1:0]    wb_data_c;

    // Register file; sources are read combinationally at acceptance, so a
    // write-back to srca/srcb never affects the operands of the same command.
    alu_seq_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_idx    (cmd_srca),
        .rb_idx    (cmd_srcb),
        .ra_data_c (ra_data_c),
        .rb_data_c (rb_data_c),
        .we        (wb_en_c),
        .wa        (wb_idx_c),
        .wd        (wb_data_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and write-back control
    always_comb begin
        state_d      = state_q;
        start_exec_c = 1'b0;
        wb_en_c      = 1'b0;
        wb_idx_c     = dst_q;
        wb_data_c    = alu_out;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_load) begin
                        wb_en_c   = 1'b1;
                        wb_idx_c  = cmd_dst;
                        wb_data_c = cmd_imm;
                        state_d   = RESP;
                    end else begin
                        start_exec_c = 1'b1;
                        state_d      = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    wb_en_c = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags, operand/settle registers and response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            rsp_q     <= '0;
        end else begin
            cmd_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            if (start_exec_c) begin
                alu_a <= ra_data_c;
                alu_b <= rb_data_c;
                alu_s <= cmd_op;
                dst_q <= cmd_dst;
                cnt_q <= '0;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (wb_en_c) begin
                rsp_q.data <= wb_data_c;
                rsp_q.dst  <= wb_idx_c;
                rsp_q.zero <= (wb_data_c == '0);
                rsp_q.neg  <= wb_data_c[DATA_W-1];
            end
        end
    end

    assign rsp_data = rsp_q.data;
    assign rsp_dst  = rsp_q.dst;
    assign rsp_zero = rsp_q.zero;
    assign rsp_neg  = rsp_q.neg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer wired to the ALU: directed steps followed by random
// commands, all checked against an arithmetic reference model of the register file.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_dst = '0;
    logic [1:0]  cmd_srca = '0;
    logic [1:0]  cmd_srcb = '0;
    logic [15:0] cmd_imm = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_s;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_dst;
    logic        rsp_zero, rsp_neg;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [15:0] ref_r [4];
    logic [15:0] exp_data;
    logic [1:0]  exp_dst;
    int          exp_lat;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_dst(rsp_dst), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
    );

    ALU u_alu (.a(alu_a), .b(alu_b), .s(alu_s), .out(alu_out));

    // Reference ALU: function table evaluated with plain modulo-65536 arithmetic
    function automatic logic [15:0] ref_alu(input int unsigned op, input int unsigned a,
                                            input int unsigned b);
        int unsigned r;
        case (op)
            0:  r = a + b;
            1:  r = a + 65536 - b;
            2:  r = b + 65536 - a;
            3:  r = 0;
            4:  r = 1;
            5:  r = 65535;
            6:  r = 65536 - a;
            7:  r = 65536 - b;
            8:  r = 65535 - a;
            9:  r = 65535 - b;
            10: r = a + 1;
            11: r = b + 1;
            12: r = a + 65535;
            13: r = b + 65535;
            14: r = a & b;
            15: r = a | b;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [15:0] imm);
        cmd_load = ld; cmd_op = op; cmd_dst = dst;
        cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
    endtask

    // Present a command, wait for acceptance, update the model
    task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [15:0] imm);
        int n;
        @(negedge clk);
        drive(ld, op, dst, sa, sb, imm);
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(cmd_ready), 32'd0);
        if (ld) begin
            exp_data = imm;
            exp_lat  = 1;
        end else begin
            chk("alu_a", 32'(alu_a), 32'(ref_r[sa]));
            chk("alu_b", 32'(alu_b), 32'(ref_r[sb]));
            chk("alu_s", 32'(alu_s), 32'(op));
            exp_data = ref_alu(32'(op), 32'(ref_r[sa]), 32'(ref_r[sb]));
            exp_lat  = int'(SETTLE);
        end
        exp_dst     = dst;
        ref_r[dst]  = exp_data;
    endtask

    // Wait for the response, check it, optionally stall, then hand it off.
    // With pend set, a new command is held on cmd_valid during the stall.
    task automatic collect(input int hold, input bit pend, input logic ld, input logic [3:0] op,
                           input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [15:0] imm);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 50);
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_dst", 32'(rsp_dst), 32'(exp_dst));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_data == 16'h0000));
        chk("rsp_neg", 32'(rsp_neg), 32'(exp_data[15]));
        if (pend) drive(ld, op, dst, sa, sb, imm);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(rsp_data), 32'(exp_data));
            chk("stall_rsp_dst", 32'(rsp_dst), 32'(exp_dst));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, "_alu_s"}, 32'(alu_s), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_dst"}, 32'(rsp_dst), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_rsp_neg"}, 32'(rsp_neg), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic       r_ld;
        for (int i = 0; i < 4; i++) ref_r[i] = '0;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        // Loads
        issue(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 16'd64);
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 16'd32);
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);

        // Directed ALU ops
        issue(1'b0, 4'd0,  2'd2, 2'd0, 2'd1, 16'd0);   // R2 = R0 + R1
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd2,  2'd3, 2'd0, 2'd1, 16'd0);   // R3 = R1 - R0
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd14, 2'd2, 2'd0, 2'd1, 16'd0);   // R2 = R0 & R1
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd5,  2'd3, 2'd0, 2'd1, 16'd0);   // R3 = 0xFFFF
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd10, 2'd0, 2'd0, 2'd1, 16'd0);   // R0 = R0 + 1
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd8,  2'd1, 2'd0, 2'd1, 16'd0);   // R1 = ~R0
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);

        // Stalled response with a pending command behind it
        issue(1'b0, 4'd15, 2'd2, 2'd0, 2'd1, 16'd0);   // R2 = R0 | R1
        collect(5, 1'b1, 1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 16'h1234);
        issue(1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 16'h1234);
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            r_ld = (($urandom % 4) == 0);
            issue(r_ld, 4'($urandom % 16), 2'($urandom % 4), 2'($urandom % 4),
                  2'($urandom % 4), 16'($urandom));
            collect(int'($urandom % 3), 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        end

        // Reset in the middle of an ALU operation
        issue(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 16'hBEEF);
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);
        issue(1'b0, 4'd15, 2'd2, 2'd2, 2'd2, 16'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midexec_reset");
        for (int i = 0; i < 4; i++) ref_r[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * int'(SETTLE) + 2; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_abort", 32'(seen), 32'd0);
        chk("ready_after_abort", 32'(cmd_ready), 32'd1);
        issue(1'b0, 4'd15, 2'd3, 2'd2, 2'd2, 16'd0);   // R2 must read back as 0
        collect(0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
